// File: rtl/vc_wormhole_switch_if.sv
// Bundle of per-VC input flit lanes and the single registered output lane of the switch.
// A flit moves on a lane in any cycle where its valid and ready are both high. Ready may
// depend on valid in the same cycle. Valid does not depend on ready.
interface vc_wormhole_switch_if #(
    parameter int DATA_W = 32,
    parameter int NUM_VC = 4
);
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic [NUM_VC*DATA_W-1:0] vc_data;
    logic [NUM_VC-1:0]        vc_valid;
    logic [NUM_VC-1:0]        vc_head;
    logic [NUM_VC-1:0]        vc_tail;
    logic [NUM_VC-1:0]        vc_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_head;
    logic                     out_tail;
    logic [VC_W-1:0]          out_vc;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  vc_data, vc_valid, vc_head, vc_tail,
        output vc_ready,
        output out_data, out_head, out_tail, out_vc, out_valid,
        input  out_ready
    );

    modport master (
        output vc_data, vc_valid, vc_head, vc_tail,
        input  vc_ready,
        input  out_data, out_head, out_tail, out_vc, out_valid,
        output out_ready
    );
endinterface

// File: rtl/vc_wormhole_switch.sv
// N-VC to one-output wormhole switch stage: arbitrates on head flits, keeps the grant until
// the tail flit, and drives a registered valid/ready output.
module vc_wormhole_switch #(
    parameter int DATA_W   = 32,
    parameter int NUM_VC   = 4,
    parameter int ARB_MODE = 0,
    localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_wormhole_switch_if.slave   sw,
    output logic                  err_orphan,
    output logic                  dbg_state
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]   owner_q, owner_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_head_q, out_head_d;
    logic              out_tail_q, out_tail_d;
    logic [VC_W-1:0]   out_vc_q, out_vc_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    logic              can_load;
    logic [NUM_VC-1:0] cand;
    logic [NUM_VC-1:0] ready_c;
    logic [VC_W-1:0]   winner;
    logic [VC_W-1:0]   sel;
    logic              found;
    logic              xfer;
    int                rr_idx;

    function automatic logic [VC_W-1:0] vc_inc(input logic [VC_W-1:0] v);
        return (int'(v) == NUM_VC - 1) ? '0 : v + VC_W'(1);
    endfunction

    always_comb begin
        can_load = !out_valid_q || sw.out_ready;
        cand     = sw.vc_valid & sw.vc_head;
        winner   = '0;
        found    = 1'b0;
        rr_idx   = 0;
        // Scan from the far end so the last hit is the highest-priority candidate.
        if (ARB_MODE == 1) begin
            for (int i = NUM_VC - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    winner = i[VC_W-1:0];
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_VC - 1; k >= 0; k--) begin
                rr_idx = int'(rr_ptr_q) + k;
                if (rr_idx >= NUM_VC) rr_idx = rr_idx - NUM_VC;
                if (cand[rr_idx[VC_W-1:0]]) begin
                    winner = rr_idx[VC_W-1:0];
                    found  = 1'b1;
                end
            end
        end

        sel     = (state_q == LOCKED) ? owner_q : winner;
        ready_c = '0;
        if (state_q == LOCKED)
            ready_c[owner_q] = can_load;
        else if (found)
            ready_c[winner] = can_load;
        xfer = |(sw.vc_valid & ready_c);

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        out_data_d  = out_data_q;
        out_head_d  = out_head_q;
        out_tail_d  = out_tail_q;
        out_vc_d    = out_vc_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        // A load in the same cycle as a drain keeps out_valid high.
        if (xfer) begin
            out_data_d  = sw.vc_data[sel*DATA_W +: DATA_W];
            out_head_d  = sw.vc_head[sel];
            out_tail_d  = sw.vc_tail[sel];
            out_vc_d    = sel;
            out_valid_d = 1'b1;
        end else if (sw.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                err_d = |(sw.vc_valid & ~sw.vc_head);
                if (xfer) begin
                    if (sw.vc_tail[winner]) begin
                        rr_ptr_d = vc_inc(winner);
                    end else begin
                        state_d = LOCKED;
                        owner_d = winner;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    err_d = sw.vc_head[owner_q];
                    if (sw.vc_tail[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = vc_inc(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            out_data_q  <= '0;
            out_head_q  <= 1'b0;
            out_tail_q  <= 1'b0;
            out_vc_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            out_data_q  <= out_data_d;
            out_head_q  <= out_head_d;
            out_tail_q  <= out_tail_d;
            out_vc_q    <= out_vc_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign sw.vc_ready  = reset ? '0 : ready_c;
    assign sw.out_data  = out_data_q;
    assign sw.out_head  = out_head_q;
    assign sw.out_tail  = out_tail_q;
    assign sw.out_vc    = out_vc_q;
    assign sw.out_valid = out_valid_q;
    assign err_orphan   = err_q;
    assign dbg_state    = (state_q == LOCKED);
endmodule

// File: tb/tb_vc_wormhole_switch.sv
// Bench for vc_wormhole_switch: directed scenarios plus randomized packet traffic in both
// arbitration modes, checked against a queue-based reference model.
module tb_vc_wormhole_switch;
    localparam int DATA_W = 32;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;
    localparam int FW     = VC_W + 2 + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [NUM_VC*DATA_W-1:0] vc_data;
    logic [NUM_VC-1:0]        vc_valid, vc_head, vc_tail;
    logic                     out_ready;
    logic                     mode;

    vc_wormhole_switch_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC)) if0 ();
    vc_wormhole_switch_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC)) if1 ();
    logic err0, err1, dbg0, dbg1;

    assign if0.vc_data = vc_data;   assign if1.vc_data = vc_data;
    assign if0.vc_valid = vc_valid; assign if1.vc_valid = vc_valid;
    assign if0.vc_head = vc_head;   assign if1.vc_head = vc_head;
    assign if0.vc_tail = vc_tail;   assign if1.vc_tail = vc_tail;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    vc_wormhole_switch #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .ARB_MODE(0)) dut_rr (
        .clk(clk), .reset(reset), .sw(if0), .err_orphan(err0), .dbg_state(dbg0));
    vc_wormhole_switch #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .ARB_MODE(1)) dut_fp (
        .clk(clk), .reset(reset), .sw(if1), .err_orphan(err1), .dbg_state(dbg1));

    logic [NUM_VC-1:0] o_ready;
    logic [DATA_W-1:0] o_data;
    logic [VC_W-1:0]   o_vc;
    logic              o_head, o_tail, o_valid, o_err, o_dbg;
    assign o_ready = mode ? if1.vc_ready  : if0.vc_ready;
    assign o_data  = mode ? if1.out_data  : if0.out_data;
    assign o_vc    = mode ? if1.out_vc    : if0.out_vc;
    assign o_head  = mode ? if1.out_head  : if0.out_head;
    assign o_tail  = mode ? if1.out_tail  : if0.out_tail;
    assign o_valid = mode ? if1.out_valid : if0.out_valid;
    assign o_err   = mode ? err1 : err0;
    assign o_dbg   = mode ? dbg1 : dbg0;

    // ---------------- scoreboard / reference model ----------------
    logic [FW-1:0] exp_q[$];
    bit m_locked;
    int m_owner, m_rr;
    bit m_err;
    int n_vec, n_miss;

    int  pos[NUM_VC];
    int  len[NUM_VC];
    bit  use_src, inject;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_err    = 1'b0;
    endfunction

    function automatic void src_reset();
        for (int i = 0; i < NUM_VC; i++) begin
            pos[i] = 0;
            len[i] = $urandom_range(1, 4);
        end
    endfunction

    function automatic logic [NUM_VC-1:0] model_ready();
        logic [NUM_VC-1:0] r;
        int i;
        r = '0;
        if (reset) return r;
        if (exp_q.size() != 0 && !out_ready) return r;
        if (m_locked) begin
            r[m_owner] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                i = mode ? k : (m_rr + k) % NUM_VC;
                if (vc_valid[i] && vc_head[i]) begin
                    r[i] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic void model_advance(input logic [NUM_VC-1:0] er);
        int w;
        bit nerr;
        w = -1;
        for (int i = 0; i < NUM_VC; i++) if (vc_valid[i] && er[i]) w = i;
        nerr = 1'b0;
        if (!m_locked) nerr = |(vc_valid & ~vc_head);
        else if (w >= 0 && vc_head[w]) nerr = 1'b1;
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (w >= 0) begin
            exp_q.push_back({VC_W'(w), vc_head[w], vc_tail[w], vc_data[w*DATA_W +: DATA_W]});
            if (!m_locked) begin
                if (vc_tail[w]) m_rr = (w + 1) % NUM_VC;
                else begin
                    m_locked = 1'b1;
                    m_owner  = w;
                end
            end else if (vc_tail[w]) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % NUM_VC;
            end
        end
        m_err = nerr;
    endfunction

    function automatic void src_advance(input logic [NUM_VC-1:0] r);
        for (int i = 0; i < NUM_VC; i++) begin
            if (vc_valid[i] && r[i]) begin
                if (pos[i] == len[i] - 1) begin
                    pos[i] = 0;
                    len[i] = $urandom_range(1, 4);
                end else begin
                    pos[i]++;
                end
            end
        end
    endfunction

    // Called at posedge+1 with inputs already driven; checks at the falling edge.
    task automatic step();
        logic [NUM_VC-1:0] er;
        @(negedge clk);
        if (reset) begin
            model_reset();
            if (use_src) src_reset();
        end
        er = model_ready();
        check("vc_ready", 64'(o_ready), 64'(er));
        check("out_valid", 64'(o_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("out_flit", 64'({o_vc, o_head, o_tail, o_data}), 64'(exp_q[0]));
        else if (reset)
            check("rst_flit", 64'({o_vc, o_head, o_tail, o_data}), 64'(0));
        check("err_orphan", 64'(o_err), 64'(m_err));
        check("fsm_state", 64'(o_dbg), 64'(m_locked));
        if (!reset) model_advance(er);
        if (use_src && !reset) src_advance(o_ready);
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drv(input logic [NUM_VC-1:0] v, input logic [NUM_VC-1:0] h,
                       input logic [NUM_VC-1:0] t, input logic r);
        vc_valid  = v;
        vc_head   = h;
        vc_tail   = t;
        out_ready = r;
        for (int i = 0; i < NUM_VC; i++) vc_data[i*DATA_W +: DATA_W] = $urandom();
        step();
    endtask

    task automatic src_drive(input int ready_pct);
        for (int i = 0; i < NUM_VC; i++) begin
            vc_valid[i] = ($urandom_range(0, 99) < 60);
            vc_head[i]  = (pos[i] == 0);
            vc_tail[i]  = (pos[i] == len[i] - 1);
            if (inject && $urandom_range(0, 31) == 0) vc_head[i] = ~vc_head[i];
            vc_data[i*DATA_W +: DATA_W] = $urandom();
        end
        out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0; n_miss = 0;
        reset = 1'b1; mode = 1'b0; use_src = 1'b0; inject = 1'b0;
        vc_valid = '0; vc_head = '0; vc_tail = '0; vc_data = '0; out_ready = 1'b0;
        model_reset();
        src_reset();
        @(posedge clk); #1;
        drv(4'h0, 4'h0, 4'h0, 1'b1);
        drv(4'hF, 4'hF, 4'hF, 1'b1);
        reset = 1'b0;

        // Single-flit packets on every VC: round-robin 0,1,2,3,0.
        repeat (5) drv(4'hF, 4'hF, 4'hF, 1'b1);

        // VC2 three-flit packet, VC0/VC1 heads held off, 4-cycle stall before the tail.
        drv(4'b0100, 4'b0100, 4'b0000, 1'b1);
        drv(4'b0111, 4'b0011, 4'b0011, 1'b1);
        repeat (4) drv(4'b0111, 4'b0011, 4'b0111, 1'b0);
        drv(4'b0111, 4'b0011, 4'b0111, 1'b1);
        repeat (3) drv(4'b0011, 4'b0011, 4'b0011, 1'b1);

        // Orphan body flit in IDLE.
        drv(4'b0010, 4'b0000, 4'b0000, 1'b1);
        drv(4'b0000, 4'b0000, 4'b0000, 1'b1);
        drv(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Reset right after a head is accepted, then a fresh VC0 packet.
        drv(4'b0001, 4'b0001, 4'b0000, 1'b1);
        reset = 1'b1;
        drv(4'b0000, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        drv(4'b0001, 4'b0001, 4'b0001, 1'b1);
        drv(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Fixed-priority instance: VC1 always beats VC3.
        reset = 1'b1; mode = 1'b1;
        drv(4'b0000, 4'b0000, 4'b0000, 1'b1);
        reset = 1'b0;
        repeat (6) drv(4'b1010, 4'b1010, 4'b1010, 1'b1);

        // Random packet traffic, fixed priority.
        reset = 1'b1;
        drv(4'b0000, 4'b0000, 4'b0000, 1'b1);
        reset = 1'b0;
        src_reset();
        use_src = 1'b1; inject = 1'b1;
        repeat (400) begin
            src_drive(75);
            step();
        end

        // Random packet traffic, round-robin, with occasional mid-run resets.
        reset = 1'b1; mode = 1'b0;
        src_drive(75);
        step();
        reset = 1'b0;
        repeat (1500) begin
            reset = ($urandom_range(0, 199) == 0);
            src_drive($urandom_range(0, 1) ? 90 : 50);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
